// File: rtl/btb_if.sv
// Lookup/update/flush bundle between the BHT/MEM stage and the branch target buffer.
// The master drives requests and updates. The slave (the BTB) answers with hit, target and busy status.
interface btb_if;
    logic        T_NT;
    logic [31:0] b_pc;
    logic        mem_is_branch;
    logic        PCSrc;
    logic [31:0] mem_pc;
    logic [31:0] mem_target;
    logic        invalidate_i;
    logic        is_taken;
    logic [31:0] btb_target;
    logic        init_busy;

    modport master (
        output T_NT, b_pc, mem_is_branch, PCSrc, mem_pc, mem_target, invalidate_i,
        input  is_taken, btb_target, init_busy
    );

    modport slave (
        input  T_NT, b_pc, mem_is_branch, PCSrc, mem_pc, mem_target, invalidate_i,
        output is_taken, btb_target, init_busy
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a zero-latency lookup and a one-entry-per-cycle clearing sweep.
// Optional macro BTB_BYPASS_EN forwards a same-cycle update that matches the lookup index and tag.
module branch_target_buffer #(
    parameter int BTB_ENTRIES = 256,
    parameter int INDEX_BITS  = 8,
    parameter int TAG_BITS    = 22
) (
    input logic clk,
    input logic rst_i,
    btb_if.slave bus
);

    typedef enum logic {S_INIT, S_READY} state_t;

    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(BTB_ENTRIES - 1);

    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] sweep_idx_q, sweep_idx_d;
    logic                  clr_en, upd_en;

    logic                  valid_q  [BTB_ENTRIES];
    logic [TAG_BITS-1:0]   tag_q    [BTB_ENTRIES];
    logic [31:0]           target_q [BTB_ENTRIES];

    logic [INDEX_BITS-1:0] lk_idx, up_idx;
    logic [TAG_BITS-1:0]   lk_tag, up_tag;
    logic                  arr_hit;
    logic                  is_taken_c;
    logic [31:0]           btb_target_c;
    logic                  unused_pc_bits;

    // Both PCs are word aligned, so their low two bits are never used
    assign unused_pc_bits = ^{bus.b_pc[1:0], bus.mem_pc[1:0]};

    assign lk_idx = bus.b_pc[INDEX_BITS+1:2];
    assign lk_tag = bus.b_pc[31:INDEX_BITS+2];
    assign up_idx = bus.mem_pc[INDEX_BITS+1:2];
    assign up_tag = bus.mem_pc[31:INDEX_BITS+2];

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        clr_en      = 1'b0;
        upd_en      = 1'b0;
        case (state_q)
            S_INIT: begin
                clr_en      = 1'b1;
                sweep_idx_d = sweep_idx_q + 1'b1;
                if (sweep_idx_q == LAST_IDX) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (bus.invalidate_i) begin
                    state_d     = S_INIT;
                    sweep_idx_d = '0;
                end else begin
                    upd_en = bus.mem_is_branch && bus.PCSrc;
                end
            end
            default: begin
                state_d     = S_INIT;
                sweep_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= S_INIT;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    // Table writes; clr_en and upd_en are mutually exclusive by state
    always_ff @(posedge clk) begin
        if (!rst_i) begin
            if (clr_en) begin
                valid_q[sweep_idx_q] <= 1'b0;
            end
            if (upd_en) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= bus.mem_target;
            end
        end
    end

    assign arr_hit = (state_q == S_READY) && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    always_comb begin
        is_taken_c   = 1'b0;
        btb_target_c = 32'h0;
        if (bus.T_NT && arr_hit) begin
            is_taken_c   = 1'b1;
            btb_target_c = target_q[lk_idx];
        end
`ifdef BTB_BYPASS_EN
        // upd_en already implies READY, so forwarding never fires during a sweep
        if (bus.T_NT && upd_en && (up_idx == lk_idx) && (up_tag == lk_tag)) begin
            is_taken_c   = 1'b1;
            btb_target_c = bus.mem_target;
        end
`else
        // The array holds pre-update contents, so a matching update becomes visible one cycle later
`endif
    end

    assign bus.is_taken   = is_taken_c;
    assign bus.btb_target = btb_target_c;
    assign bus.init_busy  = (state_q == S_INIT);

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: sweep timing, hit/miss, aliasing, same-cycle update, flush, reset.
module tb_branch_target_buffer;
    logic clk = 1'b0;
    logic rst_i;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    btb_if bus ();

    branch_target_buffer dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus;
        bus.T_NT          = 1'b0;
        bus.b_pc          = 32'h0;
        bus.mem_is_branch = 1'b0;
        bus.PCSrc         = 1'b0;
        bus.mem_pc        = 32'h0;
        bus.mem_target    = 32'h0;
        bus.invalidate_i  = 1'b0;
    endtask

    task automatic drive_update(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        bus.mem_is_branch = 1'b1;
        bus.PCSrc         = taken;
        bus.mem_pc        = pc;
        bus.mem_target    = tgt;
    endtask

    task automatic clear_update;
        bus.mem_is_branch = 1'b0;
        bus.PCSrc         = 1'b0;
        bus.mem_pc        = 32'h0;
        bus.mem_target    = 32'h0;
    endtask

    task automatic lookup(input logic req, input logic [31:0] pc);
        bus.T_NT = req;
        bus.b_pc = pc;
        #1;
    endtask

    // Counts observed busy cycles (bounded); the callers judge the result
    task automatic count_busy(output int n);
        n = 0;
        while (bus.init_busy === 1'b1 && n < 400) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset;
        int n;
        idle_bus();
        rst_i     = 1'b1;
        bus.T_NT  = 1'b1;
        bus.b_pc  = 32'h40;
        repeat (3) tick();
        vectors++;
        if (bus.init_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busy got %0b exp 1", bus.init_busy);
        end
        vectors++;
        if (bus.is_taken !== 1'b0 || bus.btb_target !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_out got %0b/%h exp 0/00000000", bus.is_taken, bus.btb_target);
        end
        rst_i = 1'b0;
        n = 0;
        while (bus.init_busy === 1'b1 && n < 400) begin
            vectors++;
            if (bus.is_taken !== 1'b0) begin
                miscompares++;
                $display("FAIL sweep_no_hit cycle %0d got %0b exp 0", n, bus.is_taken);
            end
            n++;
            tick();
        end
        vectors++;
        if (n != 256) begin
            miscompares++;
            $display("FAIL reset_sweep_len got %0d exp 256", n);
        end
        vectors++;
        if (bus.init_busy !== 1'b0 || bus.is_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_after_sweep busy/hit %0b/%0b exp 0/0", bus.init_busy, bus.is_taken);
        end
        idle_bus();
    endtask

    task automatic test_update_hit;
        drive_update(32'h40, 32'h100, 1'b1);
        tick();
        clear_update();
        lookup(1'b1, 32'h40);
        vectors++;
        if (bus.is_taken !== 1'b1 || bus.btb_target !== 32'h100) begin
            miscompares++;
            $display("FAIL hit_40 got %0b/%h exp 1/00000100", bus.is_taken, bus.btb_target);
        end
        lookup(1'b0, 32'h40);
        vectors++;
        if (bus.is_taken !== 1'b0 || bus.btb_target !== 32'h0) begin
            miscompares++;
            $display("FAIL no_req_40 got %0b/%h exp 0/00000000", bus.is_taken, bus.btb_target);
        end
        // Not-taken branch and taken non-branch must not allocate
        drive_update(32'hC0, 32'h700, 1'b0);
        tick();
        drive_update(32'hC4, 32'h704, 1'b1);
        bus.mem_is_branch = 1'b0;
        tick();
        clear_update();
        lookup(1'b1, 32'hC0);
        vectors++;
        if (bus.is_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL not_taken_no_alloc got %0b exp 0", bus.is_taken);
        end
        lookup(1'b1, 32'hC4);
        vectors++;
        if (bus.is_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL non_branch_no_alloc got %0b exp 0", bus.is_taken);
        end
        lookup(1'b0, 32'h0);
    endtask

    task automatic test_alias;
        lookup(1'b1, 32'h440);
        vectors++;
        if (bus.is_taken !== 1'b0 || bus.btb_target !== 32'h0) begin
            miscompares++;
            $display("FAIL alias_miss got %0b/%h exp 0/00000000", bus.is_taken, bus.btb_target);
        end
        drive_update(32'h440, 32'h300, 1'b1);
        tick();
        clear_update();
        lookup(1'b1, 32'h40);
        vectors++;
        if (bus.is_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL evicted_40 got %0b exp 0", bus.is_taken);
        end
        lookup(1'b1, 32'h443);
        vectors++;
        if (bus.is_taken !== 1'b1 || bus.btb_target !== 32'h300) begin
            miscompares++;
            $display("FAIL hit_440 got %0b/%h exp 1/00000300", bus.is_taken, bus.btb_target);
        end
        lookup(1'b0, 32'h0);
    endtask

    task automatic test_same_cycle;
        drive_update(32'h80, 32'h200, 1'b1);
        lookup(1'b1, 32'h80);
`ifdef BTB_BYPASS_EN
        vectors++;
        if (bus.is_taken !== 1'b1 || bus.btb_target !== 32'h200) begin
            miscompares++;
            $display("FAIL same_cycle_fwd got %0b/%h exp 1/00000200", bus.is_taken, bus.btb_target);
        end
`else
        vectors++;
        if (bus.is_taken !== 1'b0 || bus.btb_target !== 32'h0) begin
            miscompares++;
            $display("FAIL same_cycle_old got %0b/%h exp 0/00000000", bus.is_taken, bus.btb_target);
        end
`endif
        tick();
        clear_update();
        #1;
        vectors++;
        if (bus.is_taken !== 1'b1 || bus.btb_target !== 32'h200) begin
            miscompares++;
            $display("FAIL same_cycle_next got %0b/%h exp 1/00000200", bus.is_taken, bus.btb_target);
        end
        // Update on a different index leaves the concurrent lookup untouched
        drive_update(32'h84, 32'h600, 1'b1);
        lookup(1'b1, 32'h440);
        vectors++;
        if (bus.is_taken !== 1'b1 || bus.btb_target !== 32'h300) begin
            miscompares++;
            $display("FAIL indep_idx got %0b/%h exp 1/00000300", bus.is_taken, bus.btb_target);
        end
        tick();
        clear_update();
        lookup(1'b1, 32'h84);
        vectors++;
        if (bus.is_taken !== 1'b1 || bus.btb_target !== 32'h600) begin
            miscompares++;
            $display("FAIL hit_84 got %0b/%h exp 1/00000600", bus.is_taken, bus.btb_target);
        end
        lookup(1'b0, 32'h0);
    endtask

    task automatic test_invalidate;
        int n;
        drive_update(32'h100, 32'h400, 1'b1);
        bus.invalidate_i = 1'b1;
        #1;
        tick();
        bus.invalidate_i = 1'b0;
        clear_update();
        n = 0;
        while (bus.init_busy === 1'b1 && n < 400) begin
            // An update arriving mid-sweep (after index 0x10 was cleared) must be discarded
            if (n == 20) drive_update(32'h40, 32'h500, 1'b1);
            else clear_update();
            n++;
            tick();
        end
        clear_update();
        vectors++;
        if (n != 256) begin
            miscompares++;
            $display("FAIL inval_sweep_len got %0d exp 256", n);
        end
        lookup(1'b1, 32'h40);
        vectors++;
        if (bus.is_taken !== 1'b0 || bus.btb_target !== 32'h0) begin
            miscompares++;
            $display("FAIL inval_miss_40 got %0b/%h exp 0/00000000", bus.is_taken, bus.btb_target);
        end
        lookup(1'b1, 32'h100);
        vectors++;
        if (bus.is_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL inval_dropped_100 got %0b exp 0", bus.is_taken);
        end
        lookup(1'b1, 32'h80);
        vectors++;
        if (bus.is_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL inval_cleared_80 got %0b exp 0", bus.is_taken);
        end
        lookup(1'b0, 32'h0);
    endtask

    task automatic test_reset_mid_sweep;
        int n;
        drive_update(32'h80, 32'h200, 1'b1);
        tick();
        clear_update();
        bus.invalidate_i = 1'b1;
        tick();
        bus.invalidate_i = 1'b0;
        repeat (100) tick();
        vectors++;
        if (bus.init_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_sweep_busy got %0b exp 1", bus.init_busy);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        count_busy(n);
        vectors++;
        if (n != 256) begin
            miscompares++;
            $display("FAIL restart_sweep_len got %0d exp 256", n);
        end
        lookup(1'b1, 32'h80);
        vectors++;
        if (bus.is_taken !== 1'b0 || bus.init_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_miss_80 hit/busy %0b/%0b exp 0/0", bus.is_taken, bus.init_busy);
        end
        lookup(1'b0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_update_hit();
        test_alias();
        test_same_cycle();
        test_invalidate();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
